// File: rtl/alu_result_buffer.sv
// ============================================================================
// Module      : alu_result_buffer
// Description : Circular buffer of ALU results and flags, with sticky
//               carry/overflow flags and a saturating overflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         result,
    input  logic [2:0]               opcode,
    input  logic                     carryout,
    input  logic                     overflow,
    input  logic                     zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [2:0]               out_opcode,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clear_sticky,
    output logic                     sticky_carry,
    output logic                     sticky_overflow,
    output logic [7:0]               ovf_count
);

    localparam int              AW          = $clog2(DEPTH);
    localparam int              EW          = WIDTH + 6;
    localparam logic [AW:0]     C_FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   C_PTR_ONE   = AW'(1);
    localparam logic [7:0]      C_OVF_MAX   = 8'hFF;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           rdy_q;
    logic           sticky_carry_q, sticky_carry_d;
    logic           sticky_ovf_q, sticky_ovf_d;
    logic [7:0]     ovf_count_q, ovf_count_d;
    logic           push;
    logic           pop;
    logic [EW-1:0]  head;

    // rdy_q keeps in_ready low while reset is held and until the first edge after release.
    assign in_ready  = rdy_q && (count_q < C_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head       = mem_q[rd_ptr_q];
    assign out_data   = head[EW-1 -: WIDTH];
    assign out_opcode = head[5:3];
    assign out_flags  = head[2:0];

    assign count           = count_q;
    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_ovf_q;
    assign ovf_count       = ovf_count_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sticky_carry_d = sticky_carry_q && !clear_sticky;
        sticky_ovf_d   = sticky_ovf_q && !clear_sticky;
        ovf_count_d    = clear_sticky ? 8'd0 : ovf_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        // An accepted setting push overrides a same-cycle clear.
        if (push && carryout) begin
            sticky_carry_d = 1'b1;
        end
        if (push && overflow) begin
            sticky_ovf_d = 1'b1;
            if (clear_sticky) begin
                ovf_count_d = 8'd1;
            end else if (ovf_count_q != C_OVF_MAX) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rdy_q          <= 1'b0;
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            ovf_count_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {result, opcode, carryout, overflow, zero};
            end
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rdy_q          <= 1'b1;
            sticky_carry_q <= sticky_carry_d;
            sticky_ovf_q   <= sticky_ovf_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
// ============================================================================
// Module      : tb_alu_result_buffer
// Description : Directed bench for alu_result_buffer with a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic [2:0]  opcode;
    logic        carryout;
    logic        overflow;
    logic        zero;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_opcode;
    logic [2:0]  out_flags;
    logic [2:0]  count;
    logic        clear_sticky;
    logic        sticky_carry;
    logic        sticky_overflow;
    logic [7:0]  ovf_count;

    int          checks = 0;
    int          errors = 0;
    logic [21:0] sb_q [$];

    alu_result_buffer #(.WIDTH(16), .DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .result          (result),
        .opcode          (opcode),
        .carryout        (carryout),
        .overflow        (overflow),
        .zero            (zero),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_opcode      (out_opcode),
        .out_flags       (out_flags),
        .count           (count),
        .clear_sticky    (clear_sticky),
        .sticky_carry    (sticky_carry),
        .sticky_overflow (sticky_overflow),
        .ovf_count       (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus starting #1 after a rising edge; exp_rdy/exp_cnt < 0 skip that check.
    task automatic drive(input logic iv, input logic [15:0] d, input logic [2:0] op,
                         input logic [2:0] fl, input logic ordy, input logic clr,
                         input int exp_rdy, input int exp_cnt);
        in_valid     = iv;
        result       = d;
        opcode       = op;
        {carryout, overflow, zero} = fl;
        out_ready    = ordy;
        clear_sticky = clr;
        @(negedge clk);
        if (exp_rdy >= 0) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_cnt >= 0) chk("count", 32'(count), 32'(exp_cnt));
        if (iv && exp_rdy == 1) sb_q.push_back({d, op, fl});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic clr, input int exp_cnt);
        drive(1'b0, 16'h0, 3'd0, 3'b000, ordy, clr, -1, exp_cnt);
    endtask

    // Scoreboard monitor: a pop is committed at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop actual=%0h required=none (unexpected output)",
                         {out_data, out_opcode, out_flags});
            end else begin
                if ({out_data, out_opcode, out_flags} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL pop actual=%0h required=%0h",
                             {out_data, out_opcode, out_flags}, sb_q[0]);
                end
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; result = '0; opcode = '0;
        carryout = 1'b0; overflow = 1'b0; zero = 1'b0;
        out_ready = 1'b0; clear_sticky = 1'b0;

        // Reset state
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_all", 32'({out_data, out_opcode, out_flags}), 0);
        chk("rst_sticky", 32'({sticky_carry, sticky_overflow, ovf_count}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1'b0, 1'b0, 0);
        chk("rdy_after_release", 32'(in_ready), 1);

        // Single push, one-cycle latency
        drive(1'b1, 16'h0005, 3'd0, 3'b000, 1'b0, 1'b0, 1, 0);
        chk("lat_out_valid", 32'(out_valid), 1);
        chk("lat_out_data", 32'(out_data), 32'h0005);
        chk("lat_count", 32'(count), 1);
        idle(1'b1, 1'b0, 1);
        chk("drain1_count", 32'(count), 0);

        // Fill to full, drop fifth, drain in order
        for (int i = 1; i <= 4; i++)
            drive(1'b1, 16'(i), 3'(i), 3'b001, 1'b0, 1'b0, 1, i - 1);
        drive(1'b1, 16'h0005, 3'd5, 3'b001, 1'b0, 1'b0, 0, 4);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 4 - i);
        chk("drain4_count", 32'(count), 0);

        // Full with simultaneous pop attempt and push attempt
        for (int i = 0; i < 4; i++)
            drive(1'b1, 16'h0010 + 16'(i), 3'd7, 3'b000, 1'b0, 1'b0, 1, i);
        drive(1'b1, 16'h0099, 3'd1, 3'b000, 1'b1, 1'b0, 0, 4);
        idle(1'b0, 1'b0, 3);
        chk("full_pop_rdy", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 3 - i);

        // Streaming 10 entries across pointer wrap
        for (int i = 0; i < 10; i++)
            drive(1'b1, 16'(i), 3'(i), {i[0], 1'b0, (i == 0)}, 1'b1, 1'b0, 1, (i == 0) ? 0 : 1);
        idle(1'b1, 1'b0, 1);
        chk("stream_count", 32'(count), 0);
        chk("stream_sticky_c", 32'(sticky_carry), 1);
        chk("stream_sticky_o", 32'(sticky_overflow), 0);

        // Sticky clear, set-wins, dropped-flag immunity, saturation
        idle(1'b0, 1'b1, 0);
        chk("clr_sticky_c", 32'(sticky_carry), 0);
        drive(1'b1, 16'h0100, 3'd2, 3'b010, 1'b1, 1'b1, 1, 0);
        chk("setwin_sticky_o", 32'(sticky_overflow), 1);
        chk("setwin_ovf_count", 32'(ovf_count), 1);
        chk("setwin_count", 32'(count), 1);
        idle(1'b1, 1'b0, 1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 16'h0200 + 16'(i), 3'd3, 3'b000, 1'b0, 1'b0, 1, i);
        drive(1'b1, 16'h02FF, 3'd3, 3'b110, 1'b0, 1'b0, 0, 4);
        chk("drop_ovf_count", 32'(ovf_count), 1);
        chk("drop_sticky_c", 32'(sticky_carry), 0);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 4 - i);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'(i), 3'd4, 3'b010, 1'b1, 1'b0, 1, (i == 0) ? 0 : 1);
            if (i == 99) chk("ovf_count_101", 32'(ovf_count), 101);
        end
        idle(1'b1, 1'b0, 1);
        chk("ovf_sat", 32'(ovf_count), 255);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'h0300 + 16'(i), 3'd6, 3'b100, 1'b0, 1'b0, 1, i);
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_sticky_c", 32'(sticky_carry), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_sticky", 32'({sticky_carry, sticky_overflow, ovf_count}), 0);
        chk("arst_out_all", 32'({out_data, out_opcode, out_flags}), 0);
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        chk("held_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1'b0, 1'b0, 0);
        drive(1'b1, 16'h0077, 3'd5, 3'b001, 1'b0, 1'b0, 1, 0);
        idle(1'b1, 1'b0, 1);
        chk("final_count", 32'(count), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result data width matching myalu result.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer has ALU result this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer can accept an entry.
REQ-007 SHALL have port result  input  WIDTH  ALU result.
REQ-008 SHALL have port opcode  input  3  opcode that produced result.
REQ-009 SHALL have ports carryout, overflow, zero  input  1 each  ALU flags.
REQ-010 SHALL have port out_valid  output  1  head entry available.
REQ-011 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-012 SHALL have port out_data  output  WIDTH  head entry result.
REQ-013 SHALL have port out_opcode  output  3  head entry opcode.
REQ-014 SHALL have port out_flags  output  3  head entry {carryout, overflow, zero}.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port clear_sticky  input  1  synchronous clear of sticky flags and ovf_count.
REQ-017 SHALL have ports sticky_carry, sticky_overflow  output  1 each  accumulated flags.
REQ-018 SHALL have port ovf_count  output  8  saturating count of accepted entries with overflow=1.

Function
REQ-019 SHALL store each entry as {result, opcode, carryout, overflow, zero} in a circular buffer of DEPTH entries.
REQ-020 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-021 SHALL drive in_ready = (count < DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-022 SHALL drive out_valid = (count != 0); out_data/out_opcode/out_flags SHALL reflect head entry whenever out_valid=1.
REQ-023 SHALL give push-to-out_valid latency of exactly 1 cycle (entry visible the cycle after the accepting edge); no same-cycle fall-through.
REQ-024 SHALL wrap read and write pointers modulo DEPTH with no entry loss or duplication.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-026 Full (count=DEPTH): in_ready=0, in_valid ignored even if a pop occurs same cycle; in_ready returns 1 the cycle after the pop.
REQ-027 Empty: pop not possible; out_data/out_opcode/out_flags hold last values (don't-care to consumer).
REQ-028 SHALL set sticky_carry / sticky_overflow on an accepted push whose carryout / overflow is 1; flags remain set until clear_sticky or reset.
REQ-029 SHALL increment ovf_count on each accepted push with overflow=1, saturating at 255.
REQ-030 clear_sticky and a setting push in the same cycle: set wins (flag=1, ovf_count=1); clear_sticky does not affect buffer contents or count.
REQ-031 Flags not accepted (in_valid=1, in_ready=0) SHALL NOT affect sticky state or ovf_count.

Reset
REQ-032 On reset assertion, immediately (asynchronously): count=0, pointers=0, out_valid=0, in_ready=0 while reset held, sticky_carry=0, sticky_overflow=0, ovf_count=0, out_data=0, out_opcode=0, out_flags=0.
REQ-033 Reset mid-operation SHALL discard all stored entries; in_ready=1 on first clock edge after deassertion, no entry accepted on that edge's preceding cycles.

Verification
REQ-034 Push result=16'h0005 opcode=0 flags=000, out_ready=0 -> next cycle out_valid=1, out_data=0005, count=1.
REQ-035 Push 4 entries 1,2,3,4 with out_ready=0, then 5th in_valid -> in_ready=0 at count=4, entry 5 dropped; drain yields 1,2,3,4 in order.
REQ-036 Continuous push/pop (in_valid=out_ready=1) of 10 entries 0..9 -> count stays 1 after first push, outputs 0..9 in order across pointer wrap.
REQ-037 Push with overflow=1 while clear_sticky=1 -> sticky_overflow=1, ovf_count=1; 300 overflow pushes -> ovf_count=255.
REQ-038 Assert reset with count=3 -> count=0, out_valid=0, sticky flags 0 without waiting for a clock edge.
REQ-039 Full buffer, out_ready=1 and in_valid=1 same cycle -> one pop, no push, count=3, in_ready=1 next cycle.
